// File: rtl/gf2_pkg.sv
// Shared GF(2) helpers for Karatsuba-style carry-less multiply sequencers:
// the sequencer state encoding and the three-product overlap-sum recombination.
package gf2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_LO  = 3'd1,
    MUL_HI  = 3'd2,
    MUL_MID = 3'd3,
    DONE    = 3'd4
  } clmul_state_e;

  // Widest operand any controller may use; the recombination works on a
  // container this wide so one function serves every operand width.
  localparam int GF2_MAX_N  = 64;
  localparam int GF2_WIDE_W = 2 * GF2_MAX_N - 1;

  typedef logic [GF2_WIDE_W-1:0] gf2_wide_t;

  // Karatsuba overlap-sum for half width h:
  //   p = z0 ^ ((z0 ^ z1 ^ z2) << h) ^ (z2 << 2h)
  // z0/z1/z2 must be zero above bit 2h-2; the result is zero above bit 4h-2.
  function automatic gf2_wide_t karatsuba_recombine(
    input gf2_wide_t   z0,
    input gf2_wide_t   z1,
    input gf2_wide_t   z2,
    input int unsigned h
  );
    gf2_wide_t m;
    m = z0 ^ z1 ^ z2;
    return z0 ^ (m << h) ^ (z2 << (2 * h));
  endfunction

endpackage

// File: rtl/clmul_half.sv
// Purely combinational HxH carry-less multiplier (schoolbook shift-and-XOR).
// The product of two degree-(H-1) polynomials has 2H-1 coefficients.
module clmul_half #(
  parameter int H = 16
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  output logic [2*H-2:0] z
);

  localparam int ZW = 2 * H - 1;

  logic [ZW-1:0] x_ext;
  logic [ZW-1:0] acc [H+1];

  assign x_ext  = {{(H-1){1'b0}}, x};
  assign acc[0] = '0;

  // One shifted partial product per bit of y, folded into an XOR chain.
  for (genvar gi = 0; gi < H; gi++) begin : g_pp
    assign acc[gi+1] = acc[gi] ^ (y[gi] ? (x_ext << gi) : '0);
  end

  assign z = acc[H];

endmodule

// File: rtl/clmul32_seq.sv
// Multi-cycle N x N carry-less multiplier. One clmul_half instance is shared
// across the lo, hi and mid Karatsuba sub-products over three cycles; the
// overlap-sum is applied on the mid cycle and the 2N-1 bit product is held
// on p under a valid/ready handshake.
module clmul32_seq
  import gf2_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] p,
  output logic           busy
);

  localparam int H  = N / 2;
  localparam int ZW = 2 * H - 1;
  localparam int PW = 2 * N - 1;

  clmul_state_e state_q, state_d;
  logic [N-1:0]  ra_q, ra_d;
  logic [N-1:0]  rb_q, rb_d;
  logic [ZW-1:0] z0_q, z0_d;
  logic [ZW-1:0] z1_q, z1_d;
  logic [ZW-1:0] z2_q, z2_d;
  logic [PW-1:0] p_q, p_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  logic [H-1:0]  mul_x;
  logic [H-1:0]  mul_y;
  logic [ZW-1:0] mul_z;
  logic          accept;

  // Accepting in DONE needs only out_ready, so there is no path from in_valid.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign p         = p_q;

  // Shared multiplier operand select, driven purely from registered state.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state_q)
      MUL_LO: begin
        mul_x = ra_q[H-1:0];
        mul_y = rb_q[H-1:0];
      end
      MUL_HI: begin
        mul_x = ra_q[N-1:H];
        mul_y = rb_q[N-1:H];
      end
      MUL_MID: begin
        mul_x = ra_q[H-1:0] ^ ra_q[N-1:H];
        mul_y = rb_q[H-1:0] ^ rb_q[N-1:H];
      end
      default: ;
    endcase
  end

  clmul_half #(
    .H(H)
  ) u_clmul_half (
    .x(mul_x),
    .y(mul_y),
    .z(mul_z)
  );

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    z0_d    = z0_q;
    z1_d    = z1_q;
    z2_d    = z2_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ra_d    = a;
          rb_d    = b;
          state_d = MUL_LO;
        end
      end
      MUL_LO: begin
        z0_d    = mul_z;
        state_d = MUL_HI;
      end
      MUL_HI: begin
        z2_d    = mul_z;
        state_d = MUL_MID;
      end
      MUL_MID: begin
        // The mid product is used straight off the multiplier so the final
        // product is ready in the same cycle z1 is captured.
        z1_d    = mul_z;
        p_d     = PW'(karatsuba_recombine(gf2_wide_t'(z0_q), gf2_wide_t'(mul_z),
                                          gf2_wide_t'(z2_q), H));
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (accept) begin
            ra_d    = a;
            rb_d    = b;
            state_d = MUL_LO;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State, operand, sub-product and output registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ra_q        <= '0;
      rb_q        <= '0;
      z0_q        <= '0;
      z1_q        <= '0;
      z2_q        <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      z0_q        <= z0_d;
      z1_q        <= z1_d;
      z2_q        <= z2_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_clmul32_seq.sv
// Scoreboard bench for clmul32_seq: the driver pushes expected products on
// acceptance, a separate monitor pops and compares on each output transfer.
module tb_clmul32_seq;

  localparam int N  = 32;
  localparam int PW = 2 * N - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] p;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_acc = 0;

  logic [PW-1:0] exp_q [$];
  int            lat_q [$];

  logic rand_ready   = 1'b0;
  logic manual_ready = 1'b1;
  logic rnd_bit      = 1'b1;

  clmul32_seq #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p        (p),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  assign out_ready = rand_ready ? rnd_bit : manual_ready;

  // Bitwise schoolbook reference: XOR of shifted copies of x for each set bit of y.
  function automatic logic [PW-1:0] ref_clmul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (y[i]) r = r ^ (PW'(x) << i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic [PW-1:0] e);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    a = x;
    b = y;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        lat_q.push_back(cyc);
        last_acc = cyc;
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    $display("send a=0x%08h b=0x%08h exp=0x%016h accepted=%0d", x, y, e, ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no acceptance, want acceptance within 200 cycles");
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 4000; t++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compares each transfer, checks latency and hold stability.
  initial begin
    logic          hold;
    logic [PW-1:0] hold_p;
    hold = 1'b0;
    hold_p = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_p", 64'(p), 64'(hold_p));
      end
      if (out_valid && !hold && lat_q.size() > 0)
        chk("latency", 64'(cyc - lat_q.pop_front()), 64'd4);
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        hold = 1'b1;
        hold_p = p;
      end else begin
        hold = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got p=0x%0h, want no output", p);
        end else begin
          logic [PW-1:0] e;
          e = exp_q.pop_front();
          $display("recv p=0x%016h exp=0x%016h", p, e);
          chk("product", 64'(p), 64'(e));
        end
      end
    end
  end

  logic [N-1:0]  dir_a [5] = '{32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
  logic [N-1:0]  dir_b [5] = '{32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0006};
  logic [PW-1:0] dir_p [5] = '{63'h0000_0001_0000_0000, 63'h4000_0000_0000_0000,
                               63'h5555_5555_5555_5555, 63'h0000_0000_FFFF_FFFF,
                               63'h0000_0000_0000_000A};

  initial begin
    int acc_cyc [4];
    logic [N-1:0] x;
    logic [N-1:0] y;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_p", 64'(p), 64'd0);
    rst = 1'b0;

    // Basic product and return to idle.
    manual_ready = 1'b1;
    send(32'h3, 32'h3, 63'h5);
    wait_drain();
    chk("basic_in_ready_after", 64'(in_ready), 64'd1);
    chk("basic_busy_after", 64'(busy), 64'd0);

    // Cross-half and full-overlap directed vectors.
    for (int i = 0; i < 5; i++) begin
      send(dir_a[i], dir_b[i], dir_p[i]);
      wait_drain();
    end

    // Backpressure: hold the product for 5 cycles, then release.
    manual_ready = 1'b0;
    send(32'h1234_5678, 32'h0000_0009, 63'h0000_0000_8396_E5B8);
    for (int t = 0; t < 20 && !out_valid; t++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    manual_ready = 1'b1;
    wait_drain();
    chk("bp_single_transfer", 64'(out_valid), 64'd0);

    // Back-to-back: each new pair taken in the DONE cycle.
    manual_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x = $urandom;
      y = $urandom;
      send(x, y, ref_clmul(x, y));
      acc_cyc[i] = last_acc;
    end
    for (int i = 1; i < 4; i++)
      chk("b2b_interval", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd4);
    wait_drain();

    // Reset in MUL_HI aborts the operation.
    send(32'hDEAD_BEEF, 32'hCAFE_F00D, ref_clmul(32'hDEAD_BEEF, 32'hCAFE_F00D));
    @(posedge clk);
    #1;
    chk("midop_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midop_rst_out_valid", 64'(out_valid), 64'd0);
    chk("midop_rst_p", 64'(p), 64'd0);
    chk("midop_rst_in_ready", 64'(in_ready), 64'd1);
    chk("midop_rst_busy", 64'(busy), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("midop_no_stale", 64'(out_valid), 64'd0);

    // Random pairs with random out_ready and random input gaps.
    rand_ready = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      x = $urandom;
      y = $urandom;
      send(x, y, ref_clmul(x, y));
    end
    rand_ready = 1'b0;
    manual_ready = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
